matrix_out_buffer: RTL and testbench
====================================

# matrix_out_buffer

Parametrised result buffer for the matrix coprocessor. It holds one DIM×DIM matrix of W-bit elements, loaded in parallel from the datapath's result bus. Elements leave the buffer through two paths: a registered random-access read port, addressed by row and column, for the HPS bridge; and a row-major streaming port with a valid/ready handshake, for the readback DMA. It replaces the fixed 5×5, 8-bit, combinational-read output register.

## Interface
- DIM, 5: matrix dimension; legal 1..8.
- W, 8: element width in bits.
- AW, 3: row/column index width; must satisfy 2^AW ≥ DIM.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- load  in  1  parallel load strobe.
- dataIn  in  DIM*DIM*W  matrix; element (r,c) is at dataIn[W*(r*DIM+c) +: W].
- size  in  AW+1  active dimension, sampled with load.
- load_drop  out  1  one-cycle pulse: load was rejected because a stream was busy.
- rd_en  in  1  random read request.
- row, col  in  AW each  read address.
- rd_data  out  W  registered read data.
- rd_valid  out  1  one-cycle pulse: rd_data is valid.
- rd_err  out  1  one-cycle pulse with rd_valid: address was out of range.
- start  in  1  begin a stream.
- s_data  out  W  stream element.
- s_valid  out  1  stream element valid.
- s_ready  in  1  downstream accepts.
- s_last  out  1  marks the final element of a stream; valid only with s_valid.
- busy  out  1  stream in progress.

## Operation
- Storage: DIM*DIM registers of W bits, plus sz_reg of AW+1 bits.
- Load, when load=1 and busy=0:
  - All elements are written from dataIn.
  - sz_reg gets size. If size is 0 or greater than DIM, sz_reg gets DIM instead.
- Load, when load=1 and busy=1:
  - Storage and sz_reg are unchanged.
  - load_drop pulses high for 1 cycle.
- Random read:
  - When rd_en=1 and row<sz_reg and col<sz_reg, rd_data gets element (row,col) and rd_valid=1 on the next cycle.
  - Otherwise (rd_en=1 with either index out of range), rd_data=0, rd_valid=1 and rd_err=1.
  - The read port is independent of streaming and can be used in any state.
  - A read in the same cycle as an accepted load returns the pre-load value.
- Stream FSM, with states IDLE and STREAM:
  - IDLE → STREAM when start=1, load=0 and busy=0. The cursor is set to (0,0).
  - start while busy is ignored. start together with load is also ignored; load has priority.
  - In STREAM, s_valid=1 and s_data=element(cursor). These outputs are registered.
  - On s_valid & s_ready the cursor advances row-major: col+1; at col=sz_reg-1 it moves to col=0, row+1.
  - s_last=1 when cursor=(sz_reg-1, sz_reg-1).
  - A handshake with s_last=1 returns the FSM to IDLE.
- Backpressure: while s_valid=1 and s_ready=0, s_data, s_last and the cursor hold steady.
- The stream reads the storage contents that were frozen at start. Load is blocked while busy, so those contents cannot change mid-stream.
- Reset, including mid-stream:
  - All storage clears to 0 and sz_reg=DIM.
  - rd_data=0, rd_valid=0, rd_err=0, s_data=0, s_valid=0, s_last=0, busy=0, load_drop=0.
  - The FSM returns to IDLE.

## Timing
- Load: new contents are visible to a read issued in the following cycle.
- Random read: latency 1 cycle. A new request is accepted every cycle.
- Stream start: start in cycle t gives busy=1 and s_valid=1 in cycle t+1 with element (0,0).
- Stream throughput: 1 element per cycle while s_ready=1. A full stream takes sz_reg² handshake cycles.
- Stream end: the final handshake in cycle t gives busy=0 and s_valid=0 in cycle t+1. A start in cycle t+1 is accepted.
- load_drop: asserted in the cycle after the rejected load.
- sz_reg=1: a single element, with s_last=1 on the first beat.

## Test plan
- Fixture for all scenarios: DIM=5, W=8, element(r,c)=16·r+c.
- Load/read: load with size=5, then read (3,4) → rd_data=8'h34 and rd_valid=1 one cycle later. Read (5,0) → rd_data=0 with rd_err=1.
- Reduced size: load with size=3, read (2,2) → 8'h22; read (3,0) → rd_err=1. Then start with s_ready=1 → 9 beats 00,01,02,10,11,12,20,21,22, with s_last only on 22, and busy low the cycle after.
- Backpressure: full stream with s_ready toggling 1,0,0,1,… → the sequence 00..44 is unchanged (25 beats, no duplicates or drops), and s_data holds while s_ready=0.
- Blocked load: during a stream, load all-FF → load_drop pulses once, the remaining beats still carry the original values, and a read of (0,0) after the stream returns 8'h00.
- Reset mid-stream: rst at beat 7 → next cycle s_valid=0, busy=0, and a read of (1,1) returns 0. start with load=1 in the same cycle → no stream starts and the load is accepted.

Source files
------------

// File: rtl/matrix_out_buffer.sv
// DIM x DIM result buffer: registered random-access read port plus a row-major valid/ready stream.
// Read latency 1; stream holds s_data/s_last under backpressure; loads are refused while streaming.
module matrix_out_buffer #(
  parameter int DIM = 5,
  parameter int W   = 8,
  parameter int AW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIM*DIM*W-1:0] dataIn,
  input  logic [AW:0]          size,
  output logic                 load_drop,
  input  logic                 rd_en,
  input  logic [AW-1:0]        row,
  input  logic [AW-1:0]        col,
  output logic [W-1:0]         rd_data,
  output logic                 rd_valid,
  output logic                 rd_err,
  input  logic                 start,
  output logic [W-1:0]         s_data,
  output logic                 s_valid,
  input  logic                 s_ready,
  output logic                 s_last,
  output logic                 busy
);
  localparam int N  = DIM * DIM;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW:0] DIM_SZ = (AW+1)'(DIM);
  localparam logic [AW:0] ONE_SZ = (AW+1)'(1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [W-1:0]  r_mem [N];
  logic [AW:0]   r_sz;
  state_t        r_state;
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_col;

  logic          w_rd_ok;
  logic          w_load_ok;
  logic          w_start_ok;
  logic          w_col_end;
  logic          w_next_last;
  logic [AW-1:0] w_nrow;
  logic [AW-1:0] w_ncol;
  logic [IW-1:0] w_rd_idx;
  logic [IW-1:0] w_nidx;
  logic [AW:0]   w_sz_new;
  logic [AW:0]   w_sz_m1;

  assign w_sz_m1    = r_sz - ONE_SZ;
  assign w_rd_ok    = ({1'b0, row} < r_sz) && ({1'b0, col} < r_sz);
  assign w_rd_idx   = IW'(row) * IW'(DIM) + IW'(col);
  assign w_load_ok  = load && (r_state == S_IDLE);
  assign w_start_ok = start && !load && (r_state == S_IDLE);
  assign w_sz_new   = ((size == '0) || (size > DIM_SZ)) ? DIM_SZ : size;

  // Row-major cursor advance; only meaningful while streaming.
  assign w_col_end   = ({1'b0, r_col} == w_sz_m1);
  assign w_ncol      = w_col_end ? '0 : r_col + 1'b1;
  assign w_nrow      = w_col_end ? r_row + 1'b1 : r_row;
  assign w_nidx      = IW'(w_nrow) * IW'(DIM) + IW'(w_ncol);
  assign w_next_last = ({1'b0, w_nrow} == w_sz_m1) && ({1'b0, w_ncol} == w_sz_m1);

  assign busy = (r_state == S_STREAM);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      r_sz      <= DIM_SZ;
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
      s_data    <= '0;
      s_valid   <= 1'b0;
      s_last    <= 1'b0;
      load_drop <= 1'b0;
    end else begin
      load_drop <= load && (r_state == S_STREAM);
      rd_valid  <= rd_en;
      rd_err    <= rd_en && !w_rd_ok;
      if (rd_en) rd_data <= w_rd_ok ? r_mem[w_rd_idx] : '0;

      if (w_load_ok) begin
        for (int i = 0; i < N; i++) r_mem[i] <= dataIn[W*i +: W];
        r_sz <= w_sz_new;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state <= S_STREAM;
            r_row   <= '0;
            r_col   <= '0;
            s_valid <= 1'b1;
            s_data  <= r_mem[0];
            s_last  <= (r_sz == ONE_SZ);
          end
        end
        S_STREAM: begin
          if (s_ready) begin
            if (s_last) begin
              r_state <= S_IDLE;
              s_valid <= 1'b0;
              s_last  <= 1'b0;
              s_data  <= '0;
            end else begin
              r_row  <= w_nrow;
              r_col  <= w_ncol;
              s_data <= r_mem[w_nidx];
              s_last <= w_next_last;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_out_buffer.sv
// Bench for matrix_out_buffer: table-driven reads, directed stream corner cases, and random
// traffic checked every cycle against a queue-based model of the buffer.
module tb_matrix_out_buffer;
  localparam int DIM = 5;
  localparam int W   = 8;
  localparam int AW  = 3;

  logic                 clk = 1'b0;
  logic                 rst, load, rd_en, start, s_ready;
  logic [DIM*DIM*W-1:0] dataIn;
  logic [AW:0]          size;
  logic [AW-1:0]        row, col;
  logic                 load_drop, rd_valid, rd_err, s_valid, s_last, busy;
  logic [W-1:0]         rd_data, s_data;

  matrix_out_buffer #(.DIM(DIM), .W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load(load), .dataIn(dataIn), .size(size), .load_drop(load_drop),
    .rd_en(rd_en), .row(row), .col(col), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: element array, active size, and the beats still owed by the current stream.
  int mm[DIM*DIM];
  int msz;
  int mq_d[$];
  bit mq_l[$];
  bit mbusy;

  logic [W-1:0] got_d[$];
  bit           got_l[$];

  typedef struct {
    bit            ld;
    logic [AW:0]   sz;
    logic [AW-1:0] r;
    logic [AW-1:0] c;
    logic [W-1:0]  d;
    bit            err;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_pat(input int kind);
    for (int i = 0; i < DIM*DIM; i++) begin
      if (kind == 0)      dataIn[W*i +: W] = W'(16*(i/DIM) + (i%DIM));
      else if (kind == 1) dataIn[W*i +: W] = 8'hFF;
      else                dataIn[W*i +: W] = W'($urandom);
    end
  endtask

  // Predict the post-edge outputs from the currently driven inputs, clock once, compare.
  task automatic cycle();
    bit pre_busy, was_rst, inr;
    int e_rv, e_err, e_rd, e_drop;
    pre_busy = mbusy;
    was_rst  = rst;
    e_rv = 0; e_err = 0; e_rd = 0; e_drop = 0;
    if (rst) begin
      for (int i = 0; i < DIM*DIM; i++) mm[i] = 0;
      msz = DIM; mbusy = 0; mq_d.delete(); mq_l.delete();
    end else begin
      inr    = (int'(row) < msz) && (int'(col) < msz);
      e_rv   = rd_en;
      e_err  = rd_en && !inr;
      e_rd   = inr ? mm[int'(row)*DIM + int'(col)] : 0;
      e_drop = load && pre_busy;
      if (pre_busy && s_ready) begin
        mq_d.delete(0); mq_l.delete(0);
        if (mq_d.size() == 0) mbusy = 0;
      end
      if (load && !pre_busy) begin
        for (int i = 0; i < DIM*DIM; i++) mm[i] = int'(dataIn[W*i +: W]);
        msz = (size == 0 || int'(size) > DIM) ? DIM : int'(size);
      end else if (start && !pre_busy) begin
        for (int r = 0; r < msz; r++)
          for (int c = 0; c < msz; c++) begin
            mq_d.push_back(mm[r*DIM + c]);
            mq_l.push_back(r == msz-1 && c == msz-1);
          end
        mbusy = 1;
      end
    end
    @(posedge clk); #1;
    chk("rd_valid", rd_valid, e_rv);
    chk("rd_err", rd_err, e_err);
    if (e_rv || was_rst) chk("rd_data", rd_data, e_rd);
    chk("load_drop", load_drop, e_drop);
    chk("busy", busy, mbusy);
    chk("s_valid", s_valid, mbusy);
    if (mbusy) begin
      chk("s_data", s_data, mq_d[0]);
      chk("s_last", s_last, mq_l[0]);
    end else if (was_rst) begin
      chk("rst_s_data", s_data, 0);
      chk("rst_s_last", s_last, 0);
    end
  endtask

  task automatic rd(input int r, input int c);
    rd_en = 1'b1; row = AW'(r); col = AW'(c);
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic do_load(input int kind, input int sz);
    set_pat(kind); load = 1'b1; size = (AW+1)'(sz);
    cycle();
    load = 1'b0;
  endtask

  // Start a stream and drain it; mode 0 ready=1, mode 1 ready pattern 1,0,0, else random.
  task automatic run_stream(input int mode, input int ld_at, output int drops);
    int it;
    logic [W-1:0] hold;
    bit holding;
    got_d.delete(); got_l.delete();
    drops = 0; holding = 0; hold = '0; it = 0;
    start = 1'b1; cycle(); start = 1'b0;
    chk("start_busy", busy, 1);
    while (busy && it < 300) begin
      case (mode)
        0:       s_ready = 1'b1;
        1:       s_ready = (it % 3 == 0);
        default: s_ready = 1'($urandom % 2);
      endcase
      if (holding) chk("bp_hold", s_data, hold);
      holding = s_valid && !s_ready;
      hold    = s_data;
      if (s_valid && s_ready) begin
        got_d.push_back(s_data); got_l.push_back(s_last);
      end
      if (it == ld_at) begin
        set_pat(1); load = 1'b1; size = 5;
      end
      cycle();
      load = 1'b0;
      drops += int'(load_drop);
      it++;
    end
    chk("stream_end", {30'd0, busy, s_valid}, 0);
    s_ready = 1'b1;
  endtask

  task automatic check_beats(input int n);
    chk("beat_count", got_d.size(), n*n);
    for (int k = 0; k < got_d.size() && k < n*n; k++) begin
      chk("beat_data", got_d[k], 16*(k/n) + (k%n));
      chk("beat_last", got_l[k], k == n*n-1);
    end
  endtask

  initial begin
    int drops;
    tbl[0]  = '{ld:1, sz:5, r:3, c:4, d:8'h34, err:0};
    tbl[1]  = '{ld:0, sz:0, r:5, c:0, d:8'h00, err:1};
    tbl[2]  = '{ld:0, sz:0, r:0, c:5, d:8'h00, err:1};
    tbl[3]  = '{ld:0, sz:0, r:4, c:4, d:8'h44, err:0};
    tbl[4]  = '{ld:1, sz:3, r:2, c:2, d:8'h22, err:0};
    tbl[5]  = '{ld:0, sz:0, r:3, c:0, d:8'h00, err:1};
    tbl[6]  = '{ld:0, sz:0, r:0, c:3, d:8'h00, err:1};
    tbl[7]  = '{ld:0, sz:0, r:0, c:0, d:8'h00, err:0};
    tbl[8]  = '{ld:1, sz:0, r:4, c:4, d:8'h44, err:0};
    tbl[9]  = '{ld:1, sz:7, r:4, c:4, d:8'h44, err:0};
    tbl[10] = '{ld:1, sz:1, r:0, c:0, d:8'h00, err:0};
    tbl[11] = '{ld:0, sz:0, r:0, c:1, d:8'h00, err:1};

    for (int i = 0; i < DIM*DIM; i++) mm[i] = 0;
    msz = DIM; mbusy = 0;
    load = 0; start = 0; rd_en = 0; row = '0; col = '0; s_ready = 1; size = '0; dataIn = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_busy", busy, 0);
    rd(4, 4);
    chk("reset_rd44", rd_data, 0);
    chk("reset_rd44_err", rd_err, 0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].ld) do_load(0, int'(tbl[i].sz));
      rd(int'(tbl[i].r), int'(tbl[i].c));
      chk("tbl_rd_valid", rd_valid, 1);
      chk("tbl_rd_data", rd_data, tbl[i].d);
      chk("tbl_rd_err", rd_err, tbl[i].err);
    end

    // Single-element stream: s_last on the first beat.
    run_stream(0, -1, drops);
    check_beats(1);

    do_load(0, 3);
    run_stream(0, -1, drops);
    check_beats(3);

    do_load(0, 5);
    run_stream(1, -1, drops);
    check_beats(5);

    run_stream(1, 4, drops);
    check_beats(5);
    chk("blocked_drops", drops, 1);
    rd(0, 0);
    chk("blocked_rd00", rd_data, 8'h00);

    // Read in the same cycle as an accepted load sees the old contents.
    set_pat(1); load = 1'b1; size = 5; rd_en = 1'b1; row = 3'd1; col = 3'd1;
    cycle();
    load = 1'b0; rd_en = 1'b0;
    chk("ld_rd_same", rd_data, 8'h11);
    rd(1, 1);
    chk("ld_rd_after", rd_data, 8'hFF);

    // Reset while beat 7 is on the bus.
    do_load(0, 5);
    s_ready = 1'b1; start = 1'b1; cycle(); start = 1'b0;
    for (int k = 0; k < 7; k++) cycle();
    chk("beat7", s_data, 8'h12);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_mid_s_valid", s_valid, 0);
    chk("rst_mid_busy", busy, 0);
    rd(1, 1);
    chk("rst_mid_rd11", rd_data, 8'h00);
    set_pat(0); load = 1'b1; size = 5; start = 1'b1;
    cycle();
    load = 1'b0; start = 1'b0;
    chk("ld_start_busy", busy, 0);
    rd(1, 1);
    chk("ld_start_rd11", rd_data, 8'h11);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom % 300) == 0;
      load  = ($urandom % 10) == 0;
      if (load) set_pat(2);
      size  = (AW+1)'($urandom % 8);
      start = ($urandom % 5) == 0;
      rd_en = 1'($urandom % 2);
      row   = AW'($urandom % 8);
      col   = AW'($urandom % 8);
      s_ready = ($urandom % 4) != 0;
      cycle();
    end
    rst = 0; load = 0; start = 0; rd_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
